// File: rtl/intg_code_gen_if.sv
// Handshake and code stream bundle between a window source and intg_code_gen.
interface intg_code_gen_if;
    localparam int unsigned TOT_W  = 13;
    localparam int unsigned CODE_W = 4;
    localparam int unsigned RES_W  = 5;

    logic              start;
    logic [TOT_W-1:0]  total;
    logic              busy;
    logic              x_valid;
    logic [CODE_W-1:0] X;
    logic              done;
    logic [RES_W-1:0]  residue;
    logic              err;

    modport master (
        output start, total,
        input  busy, x_valid, X, done, residue, err
    );

    modport slave (
        input  start, total,
        output busy, x_valid, X, done, residue, err
    );
endinterface

// File: rtl/intg_code_gen.sv
// Window code generator: splits a window total into SLOTS greedy 4-bit codes
// (largest first) that the integrator's code*STEP accumulator sums back to total.
module intg_code_gen #(
    parameter int unsigned SLOTS = 8,
    parameter int unsigned STEP  = 25
) (
    input logic            clk,
    input logic            reset,
    intg_code_gen_if.slave bus
);
    localparam int unsigned TOT_W     = 13;
    localparam int unsigned CODE_W    = 4;
    localparam int unsigned RES_W     = 5;
    localparam int unsigned SLOT_W    = 5;
    localparam int unsigned MAX_CODE  = 15;
    localparam int unsigned MAX_TOTAL = SLOTS * MAX_CODE * STEP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t              state;
    logic [TOT_W-1:0]    rem;
    logic [SLOT_W-1:0]   slot;

    logic                busy_q;
    logic                x_valid_q;
    logic [CODE_W-1:0]   x_q;
    logic                done_q;
    logic [RES_W-1:0]    residue_q;
    logic                err_q;

    logic [TOT_W-1:0]    enc_in_c;
    logic [TOT_W-1:0]    enc_sub_c;
    logic [CODE_W-1:0]   enc_code_c;
    logic                in_range_c;
    logic                last_slot_c;

    // The first code is registered on the accepting edge, so the encoder
    // looks at the incoming total in IDLE and at the running remainder after.
    always_comb begin
        enc_in_c = (state == IDLE) ? bus.total : rem;
    end

    // Greedy encoder: largest k with k*STEP <= input, as parallel constant compares.
    always_comb begin
        enc_code_c = '0;
        enc_sub_c  = '0;
        for (int unsigned k = 1; k <= MAX_CODE; k++) begin
            if (enc_in_c >= TOT_W'(k * STEP)) begin
                enc_code_c = CODE_W'(k);
                enc_sub_c  = TOT_W'(k * STEP);
            end
        end
    end

    always_comb begin
        in_range_c  = (32'(bus.total) <= MAX_TOTAL);
        last_slot_c = (slot == SLOT_W'(SLOTS - 1));
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rem       <= '0;
            slot      <= '0;
            busy_q    <= 1'b0;
            x_valid_q <= 1'b0;
            x_q       <= '0;
            done_q    <= 1'b0;
            residue_q <= '0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (in_range_c) begin
                            state     <= EMIT;
                            busy_q    <= 1'b1;
                            x_valid_q <= 1'b1;
                            x_q       <= enc_code_c;
                            rem       <= bus.total - enc_sub_c;
                            slot      <= '0;
                        end else begin
                            state <= ERR;
                            err_q <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (last_slot_c) begin
                        state     <= DONE;
                        x_valid_q <= 1'b0;
                        x_q       <= '0;
                        done_q    <= 1'b1;
                        residue_q <= rem[RES_W-1:0];
                    end else begin
                        x_q  <= enc_code_c;
                        rem  <= rem - enc_sub_c;
                        slot <= slot + SLOT_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy    = busy_q;
        bus.x_valid = x_valid_q;
        bus.X       = x_q;
        bus.done    = done_q;
        bus.residue = residue_q;
        bus.err     = err_q;
    end
endmodule

// File: tb/tb_intg_code_gen.sv
// Self-checking bench for intg_code_gen against a greedy-quotient reference model.
module tb_intg_code_gen;
    localparam int SLOTS = 8;
    localparam int STEP  = 25;
    localparam int NCYC  = SLOTS + 2;
    localparam int MAXT  = SLOTS * 15 * STEP;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    intg_code_gen_if bus ();

    intg_code_gen #(.SLOTS(SLOTS), .STEP(STEP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       obs_xv   [NCYC];
    logic [3:0] obs_x    [NCYC];
    logic       obs_done [NCYC];
    logic       obs_busy [NCYC];
    logic       obs_err  [NCYC];
    logic [4:0] obs_res  [NCYC];

    // Reference: q = floor(t/STEP) split into full 15s, one partial, then zeros.
    function automatic int exp_code(input int t, input int i);
        int q;
        int full;
        q    = t / STEP;
        full = q / 15;
        if (i < full) return 15;
        else if (i == full) return q % 15;
        else return 0;
    endfunction

    task automatic sample(input int c);
        obs_xv[c]   = bus.x_valid;
        obs_x[c]    = bus.X;
        obs_done[c] = bus.done;
        obs_busy[c] = bus.busy;
        obs_err[c]  = bus.err;
        obs_res[c]  = bus.residue;
    endtask

    // Pulses start with total t and records NCYC cycles from the accepting edge;
    // optionally raises start again (total xt) after cycle xc.
    task automatic run_window(input int t, input int xc, input int xt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.total = 13'(t);
        @(posedge clk); #1;
        sample(0);
        bus.start = 1'b0;
        for (int c = 1; c < NCYC; c++) begin
            @(posedge clk); #1;
            sample(c);
            if (c == xc) begin
                bus.start = 1'b1;
                bus.total = 13'(xt);
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.total = '0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.x_valid, bus.X, bus.done, bus.residue, bus.err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {bus.busy, bus.x_valid, bus.X, bus.done, bus.residue, bus.err});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_windows();
        int tv [4];
        int sum;
        tv[0] = 1000; tv[1] = MAXT; tv[2] = 0; tv[3] = 1013;
        for (int n = 0; n < 4; n++) begin
            run_window(tv[n], -1, 0);
            sum = 0;
            for (int c = 0; c < SLOTS; c++) begin
                checks++;
                if (obs_xv[c] !== 1'b1 || int'(obs_x[c]) !== exp_code(tv[n], c)
                    || obs_busy[c] !== 1'b1 || obs_done[c] !== 1'b0) begin
                    errors++;
                    $display("FAIL code t=%0d c=%0d got xv=%b X=%0d busy=%b exp xv=1 X=%0d busy=1",
                             tv[n], c, obs_xv[c], obs_x[c], obs_busy[c], exp_code(tv[n], c));
                end
                sum += STEP * int'(obs_x[c]);
            end
            checks++;
            if (obs_done[SLOTS] !== 1'b1 || obs_busy[SLOTS] !== 1'b1 || obs_xv[SLOTS] !== 1'b0
                || obs_x[SLOTS] !== 4'd0 || int'(obs_res[SLOTS]) !== tv[n] % STEP) begin
                errors++;
                $display("FAIL done_cycle t=%0d got done=%b busy=%b xv=%b res=%0d exp done=1 busy=1 xv=0 res=%0d",
                         tv[n], obs_done[SLOTS], obs_busy[SLOTS], obs_xv[SLOTS], obs_res[SLOTS], tv[n] % STEP);
            end
            checks++;
            if (obs_busy[SLOTS+1] !== 1'b0 || obs_done[SLOTS+1] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after t=%0d got busy=%b done=%b exp 0 0",
                         tv[n], obs_busy[SLOTS+1], obs_done[SLOTS+1]);
            end
            checks++;
            if (sum !== tv[n] - tv[n] % STEP) begin
                errors++;
                $display("FAIL integrate t=%0d got=%0d exp=%0d", tv[n], sum, tv[n] - tv[n] % STEP);
            end
        end
    endtask

    task automatic test_range_error();
        // Previous window was 1013, so residue must stay 13.
        run_window(MAXT + 1, -1, 0);
        checks++;
        if (obs_err[0] !== 1'b1 || obs_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse got err=%b busy=%b exp err=1 busy=0", obs_err[0], obs_busy[0]);
        end
        for (int c = 1; c < NCYC; c++) begin
            checks++;
            if (obs_err[c] !== 1'b0) begin
                errors++;
                $display("FAIL err_width c=%0d got=%b exp=0", c, obs_err[c]);
            end
        end
        for (int c = 0; c < NCYC; c++) begin
            checks++;
            if (obs_xv[c] !== 1'b0 || obs_done[c] !== 1'b0 || obs_busy[c] !== 1'b0
                || obs_res[c] !== 5'd13) begin
                errors++;
                $display("FAIL err_quiet c=%0d got xv=%b done=%b busy=%b res=%0d exp 0 0 0 13",
                         c, obs_xv[c], obs_done[c], obs_busy[c], obs_res[c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_window(1000, 3, 500);
        for (int c = 0; c < SLOTS; c++) begin
            checks++;
            if (obs_xv[c] !== 1'b1 || int'(obs_x[c]) !== exp_code(1000, c)) begin
                errors++;
                $display("FAIL ignore_start c=%0d got xv=%b X=%0d exp xv=1 X=%0d",
                         c, obs_xv[c], obs_x[c], exp_code(1000, c));
            end
        end
        run_window(500, -1, 0);
        for (int c = 0; c < SLOTS; c++) begin
            checks++;
            if (obs_xv[c] !== 1'b1 || obs_busy[c] !== 1'b1 || int'(obs_x[c]) !== exp_code(500, c)) begin
                errors++;
                $display("FAIL b2b c=%0d got xv=%b busy=%b X=%0d exp xv=1 busy=1 X=%0d",
                         c, obs_xv[c], obs_busy[c], obs_x[c], exp_code(500, c));
            end
        end
        checks++;
        if (obs_done[SLOTS] !== 1'b1 || obs_res[SLOTS] !== 5'd0) begin
            errors++;
            $display("FAIL b2b_done got done=%b res=%0d exp 1 0", obs_done[SLOTS], obs_res[SLOTS]);
        end
    endtask

    task automatic test_held_start();
        int nxv;
        int ndone;
        nxv = 0;
        ndone = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.total = 13'd500;
        repeat (2 * NCYC) begin
            @(posedge clk); #1;
            if (bus.x_valid === 1'b1) nxv++;
            if (bus.done === 1'b1) ndone++;
        end
        bus.start = 1'b0;
        checks++;
        if (nxv !== 2 * SLOTS || ndone !== 2) begin
            errors++;
            $display("FAIL held_start got xv_cycles=%0d dones=%0d exp %0d 2", nxv, ndone, 2 * SLOTS);
        end
        repeat (NCYC) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int ndone;
        @(negedge clk);
        bus.start = 1'b1;
        bus.total = 13'd2000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.x_valid, bus.X, bus.done, bus.residue, bus.err} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=0",
                     {bus.busy, bus.x_valid, bus.X, bus.done, bus.residue, bus.err});
        end
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.x_valid !== 1'b0) ndone++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (SLOTS + 2) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.x_valid !== 1'b0) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_no_resume got active_cycles=%0d exp=0", ndone);
        end
        run_window(375, -1, 0);
        for (int c = 0; c < SLOTS; c++) begin
            checks++;
            if (obs_xv[c] !== 1'b1 || int'(obs_x[c]) !== exp_code(375, c)) begin
                errors++;
                $display("FAIL after_reset c=%0d got xv=%b X=%0d exp xv=1 X=%0d",
                         c, obs_xv[c], obs_x[c], exp_code(375, c));
            end
        end
        checks++;
        if (obs_done[SLOTS] !== 1'b1 || obs_res[SLOTS] !== 5'd0) begin
            errors++;
            $display("FAIL after_reset_done got done=%b res=%0d exp 1 0", obs_done[SLOTS], obs_res[SLOTS]);
        end
    endtask

    task automatic test_random();
        int t;
        int sum;
        int nxv;
        for (int w = 0; w < 200; w++) begin
            t = int'($urandom_range(0, MAXT));
            run_window(t, -1, 0);
            sum = 0;
            nxv = 0;
            for (int c = 0; c < NCYC; c++) begin
                if (obs_xv[c] === 1'b1) begin
                    sum += STEP * int'(obs_x[c]);
                    nxv++;
                end
            end
            checks++;
            if (nxv !== SLOTS || obs_done[SLOTS] !== 1'b1 || sum !== t - t % STEP) begin
                errors++;
                $display("FAIL rand_sum t=%0d got sum=%0d codes=%0d done=%b exp sum=%0d codes=%0d done=1",
                         t, sum, nxv, obs_done[SLOTS], t - t % STEP, SLOTS);
            end
            checks++;
            if (int'(obs_res[SLOTS]) !== t % STEP) begin
                errors++;
                $display("FAIL rand_residue t=%0d got=%0d exp=%0d", t, obs_res[SLOTS], t % STEP);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.start = 1'b0;
        bus.total = '0;
        reset = 1'b1;
        test_reset();
        test_windows();
        test_range_error();
        test_back_to_back();
        test_held_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/intg_code_gen.md
# intg_code_gen

Window code generator: the transmit-side counterpart of the integrator. It takes a 13-bit window total (in units of 1, quantised by STEP=25) and emits exactly SLOTS 4-bit codes, one per clock. Fed one code per clock, the integrator's code-to-value map (code k → 25·k) and accumulator reproduce the total. Codes are assigned greedily, largest first. The block sits upstream of the integrator in test and loopback setups.

## Interface
- SLOTS, 8, codes emitted per window; legal range 1..21 so SLOTS·375 fits in 13 bits
- STEP, 25, value weight of one code LSB; fixed to match the integrator map
- clk  input  1  clock, rising-edge active
- reset  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- total  input  13  window total, sampled together with start
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- x_valid  output  1  high while X carries a code
- X  output  4  emitted code; 0 when x_valid=0
- done  output  1  one-cycle pulse after the last code
- residue  output  5  part of total not representable (total mod 25); valid when done=1, held until the next accepted start
- err  output  1  one-cycle pulse: total out of range, nothing emitted

## Operation
- States: IDLE, EMIT, DONE, ERR.
- IDLE, start=1:
  - total > SLOTS·15·STEP (3000 for SLOTS=8): go to ERR.
  - Otherwise: rem ← total, slot ← 0, go to EMIT.
- EMIT:
  - Code encoder: k = largest value in 0..15 with 25·k ≤ rem. This is combinational, 16 parallel compares against the constants 0, 25, …, 375.
  - Drive X=k, x_valid=1.
  - Register update: rem ← rem − 25·k, slot ← slot+1.
  - When slot = SLOTS−1, go to DONE.
- Resulting code pattern: ⌊q/15⌋ codes of 15, then one code of q mod 15 if non-zero, then zeros, where q = ⌊total/25⌋. The sum of 25·X over the window equals total − residue.
- DONE: done=1, residue ← rem[4:0]; rem < 25 is guaranteed here. Go to IDLE.
- ERR: err=1, x_valid=0, residue unchanged. Go to IDLE.
- start while not in IDLE is ignored; no queuing.
- Arithmetic is unsigned 13-bit. rem never underflows, because 25·k ≤ rem by construction.

## Timing
- Reset (async, low): state=IDLE, rem=0, slot=0. Outputs: busy=0, x_valid=0, X=0, done=0, err=0, residue=0.
- start sampled at rising edge T (state IDLE) → at T+1 state=EMIT, busy=1, x_valid=1, X=first code.
- x_valid is high for exactly SLOTS consecutive cycles, T+1..T+SLOTS.
- DONE cycle is T+SLOTS+1: done=1, busy=1, x_valid=0, X=0.
- At T+SLOTS+2 the block is back in IDLE with busy=0. A new start may be sampled at that edge, giving a back-to-back period of SLOTS+2 cycles.
- Error path: err=1 at T+1, busy stays 0, IDLE at T+2.
- Reset asserted mid-EMIT: outputs clear immediately (asynchronous). No done or err pulse, no partial residue update. After release the block waits in IDLE for a fresh start.
- start held high continuously: re-accepted each time the block reaches IDLE.
- All outputs are registered. X and x_valid change only on clk edges.

## Test plan
- Normal window: total=1000, start pulse → X=15,15,10,0,0,0,0,0 on 8 consecutive x_valid cycles; then done=1 with residue=0. The code sequence fed to the integrator model accumulates to 1000.
- Full scale and zero:
  - total=3000 → eight codes of 15, residue=0.
  - total=0 → eight codes of 0, done with residue=0.
- Residue and range error:
  - total=1013 → 15,15,10,0…, residue=13.
  - total=3001 → err pulse at T+1, no x_valid, residue keeps its previous value.
- Protocol: a second start (total=500) during EMIT is ignored, so the in-flight codes are unchanged. start raised in the cycle after done is accepted; for total=500 it emits 15,5,0,0,0,0,0,0.
- Reset mid-operation: reset low after the third code of total=2000 → all outputs 0 immediately, no done. After release, total=375 runs cleanly and emits 15,0,…,0.
- Randomised loopback (e.g. 200 windows): random total in 0..3000 → Σ25·X equals total − residue, and residue equals total mod 25, for every window.
